sram_bus_arbiter: RTL and testbench
===================================

Name: sram_bus_arbiter

Overview:
- Shares the single SRAM-like memory port between the instruction-fetch master (IF stage) and the data master (EX/MEM load/store path).
- Data requests have priority. A streak counter stops data traffic from starving instruction fetch.
- At most one transaction is in flight. Responses are routed back to the master that issued the request.
- Sits between the CPU core and the memory bridge.

Parameters:
- MAX_STREAK, 4: maximum consecutive data grants while inst_req is pending; after this many, inst is granted. Range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  instruction master request
- inst_wr  in  1  instruction master write flag (normally 0)
- inst_size  in  2  instruction access size: 0=byte, 1=half, 2=word
- inst_wstrb  in  4  instruction byte write strobes
- inst_addr  in  32  instruction address
- inst_wdata  in  32  instruction write data
- inst_addr_ok  out  1  instruction request accepted
- inst_data_ok  out  1  instruction response valid, one-cycle pulse
- inst_rdata  out  32  instruction read data
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  data master request fields, same meanings as the inst_* inputs
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  data response valid, one-cycle pulse
- data_rdata  out  32  data read data
- mem_req  out  1  request to memory
- mem_wr  out  1  write flag to memory
- mem_size  out  2  access size to memory
- mem_wstrb  out  4  byte write strobes to memory
- mem_addr  out  32  address to memory
- mem_wdata  out  32  write data to memory
- mem_addr_ok  in  1  memory accepted the request
- mem_data_ok  in  1  memory response valid
- mem_rdata  in  32  memory read data

Behaviour:
- Protocol:
  - A request is accepted in the cycle where req && addr_ok.
  - The response is a data_ok pulse no earlier than the cycle after acceptance.
  - A master holds req and its fields stable until addr_ok.
- FSM states: IDLE, ADDR, RESP. Registers: state, owner (0=inst, 1=data), streak counter (4 bits, saturating).
- IDLE:
  - If data_req || inst_req, latch owner and go to ADDR next cycle.
  - Arbitration: grant data if data_req && !(inst_req && streak==MAX_STREAK); otherwise grant inst.
  - Grant latency is 1 cycle; mem_req=0 in IDLE.
- Streak update at each grant:
  - Data granted while inst_req=1: streak+1, saturating at MAX_STREAK.
  - Data granted while inst_req=0: streak=0.
  - Inst granted: streak=0.
- ADDR:
  - mem_req = owner's req.
  - mem_wr/size/wstrb/addr/wdata are a combinational mux of the owner's fields.
  - Owner's addr_ok = mem_addr_ok. The non-owner's addr_ok = 0.
  - mem_addr_ok=1: go to RESP.
  - Owner req=0 (protocol violation): go to IDLE without issuing.
  - mem_data_ok in ADDR is ignored.
- RESP:
  - mem_req=0.
  - On mem_data_ok: owner's data_ok=1 for that cycle; go to IDLE.
- Response data: inst_rdata and data_rdata both equal mem_rdata, passed combinationally. Only the owner's data_ok is qualified.
- Outside ADDR: mem_* fields are driven to 0 and mem_req=0.
- Data_ok outside RESP: both data_ok outputs are 0.
- Throughput: one transaction per 3 cycles minimum (IDLE, ADDR, RESP with an immediate response).
- Simultaneous requests in IDLE: data wins unless the streak limit is hit.
- A request arriving during ADDR/RESP waits; its addr_ok stays 0.
- Reset: resetn low asynchronously forces state=IDLE, owner=0, streak=0. Consequently mem_req=0, all addr_ok/data_ok=0, all mem_* fields=0.
  - Reset mid-transaction drops it. A late mem_data_ok after reset, arriving in IDLE, is ignored.

Test Plan:
- Single inst read: inst_req=1, addr=0xBFC00000; mem_addr_ok=1 in ADDR; mem_data_ok=1 with rdata=0x3C1D0001 one cycle later -> mem_req high exactly 1 cycle, inst_addr_ok pulses once, inst_data_ok pulses with inst_rdata=0x3C1D0001, data_data_ok stays 0.
- Simultaneous requests: inst_req and data_req asserted together in IDLE -> data granted first (mem_addr = data_addr); inst granted on the next IDLE.
- Starvation guard (MAX_STREAK=4): data_req and inst_req held high continuously -> grant sequence is D,D,D,D,I,D,D,D,D,I.
- Write pass-through: data_req, wr=1, size=0, wstrb=0x4, addr=0x1C0, wdata=0x00AB0000 -> the mem_* fields match exactly during ADDR. mem_addr_ok held low for 3 cycles -> state stays ADDR and data_addr_ok stays 0 until mem_addr_ok rises.
- Response wait: mem_data_ok delayed 5 cycles -> no new mem_req is issued while in RESP; a pending inst_req sees inst_addr_ok=0 throughout.
- Async reset: resetn asserted low in RESP -> mem_req and all ok outputs drop to 0 immediately without a clock edge. After release, a stray mem_data_ok produces no data_ok pulse.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one SRAM-like memory port between the instruction
// fetch master and the data load/store master. Data has priority, and a
// saturating streak counter forces an instruction grant after MAX_STREAK
// back-to-back data grants while instruction fetch is waiting. Only one
// transaction is in flight at a time, and its response is returned to the
// master that issued it.
module sram_bus_arbiter #(
   parameter int MAX_STREAK = 4
) (
   input  logic        clk,
   input  logic        resetn,
   // instruction master
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   // data master
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   // memory port
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_RESP = 2'd2
   } state_e;

   localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

   // owner encoding: 1'b0 = instruction master, 1'b1 = data master
   state_e      state_q, state_d;
   logic        owner_q, owner_d;
   logic [3:0]  streak_q, streak_d;
   logic        grant_data_s;
   logic        owner_req_s;

   // Arbitration: data wins unless instruction fetch has waited out a full streak.
   always_comb begin
      grant_data_s = data_req && !(inst_req && (streak_q == STREAK_MAX));
   end

   // Request line of whichever master currently owns the port.
   always_comb begin
      owner_req_s = owner_q ? data_req : inst_req;
   end

   // Next-state logic for state, owner and streak counter.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      streak_d = streak_q;
      case (state_q)
         S_IDLE: begin
            if (data_req || inst_req) begin
               state_d = S_ADDR;
               owner_d = grant_data_s;
               if (grant_data_s && inst_req) begin
                  // inst is being passed over: count toward the starvation limit
                  if (streak_q >= STREAK_MAX) begin
                     streak_d = STREAK_MAX;
                  end else begin
                     streak_d = streak_q + 4'd1;
                  end
               end else begin
                  // inst granted, or data granted with nobody waiting
                  streak_d = 4'd0;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ADDR: begin
            if (!owner_req_s) begin
               // owner withdrew its request before acceptance: abandon quietly
               state_d = S_IDLE;
            end else if (mem_addr_ok) begin
               state_d = S_RESP;
            end else begin
               state_d = S_ADDR;
            end
         end
         S_RESP: begin
            if (mem_data_ok) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RESP;
            end
         end
         default: begin
            state_d  = S_IDLE;
            owner_d  = 1'b0;
            streak_d = 4'd0;
         end
      endcase
   end

   // Arbiter state registers; reset drops any transaction in flight.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         owner_q  <= 1'b0;
         streak_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         streak_q <= streak_d;
      end
   end

   // Memory-side request: owner's fields pass through only while in ADDR.
   always_comb begin
      mem_req      = 1'b0;
      mem_wr       = 1'b0;
      mem_size     = 2'd0;
      mem_wstrb    = 4'd0;
      mem_addr     = 32'd0;
      mem_wdata    = 32'd0;
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;
      if (state_q == S_ADDR) begin
         mem_req = owner_req_s;
         if (owner_q) begin
            mem_wr       = data_wr;
            mem_size     = data_size;
            mem_wstrb    = data_wstrb;
            mem_addr     = data_addr;
            mem_wdata    = data_wdata;
            data_addr_ok = mem_addr_ok;
         end else begin
            mem_wr       = inst_wr;
            mem_size     = inst_size;
            mem_wstrb    = inst_wstrb;
            mem_addr     = inst_addr;
            mem_wdata    = inst_wdata;
            inst_addr_ok = mem_addr_ok;
         end
      end else begin
         mem_req = 1'b0;
      end
   end

   // Response routing: read data is shared, only the owner's data_ok fires in RESP.
   always_comb begin
      inst_rdata   = mem_rdata;
      data_rdata   = mem_rdata;
      inst_data_ok = 1'b0;
      data_data_ok = 1'b0;
      if (state_q == S_RESP) begin
         inst_data_ok = mem_data_ok && !owner_q;
         data_data_ok = mem_data_ok && owner_q;
      end else begin
         inst_data_ok = 1'b0;
      end
   end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter (MAX_STREAK = 4): a per-cycle
// vector table for basic transactions, plus hand sequences for the streak
// limit, write pass-through with stalls, and asynchronous reset.
module tb_sram_bus_arbiter;

   localparam logic [31:0] IA = 32'hBFC0_0000;
   localparam logic [31:0] DA = 32'h0000_01C0;

   logic        clk;
   logic        resetn;
   logic        inst_req, inst_wr;
   logic [1:0]  inst_size;
   logic [3:0]  inst_wstrb;
   logic [31:0] inst_addr, inst_wdata;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_req, mem_wr;
   logic [1:0]  mem_size;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_addr_ok, mem_data_ok;
   logic [31:0] mem_rdata;

   int checks;
   int failures;

   sram_bus_arbiter #(.MAX_STREAK(4)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
      .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ireq;
      logic        dreq;
      logic        maok;
      logic        mdok;
      logic [31:0] rdata;
      logic [4:0]  exp_flags; // {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}
      logic [31:0] exp_addr;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [4:0] flags();
      return {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok};
   endfunction

   initial begin
      logic [9:0] seq;
      int         ngrant;
      checks   = 0;
      failures = 0;

      // fixed master fields: inst is a word read, data is a byte write
      inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'hF; inst_addr = IA; inst_wdata = 32'd0;
      data_wr = 1'b1; data_size = 2'd0; data_wstrb = 4'h4; data_addr = DA; data_wdata = 32'h00AB_0000;
      inst_req = 1'b0; data_req = 1'b0;
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
      resetn = 1'b0;

      // per-cycle vectors, starting from IDLE with streak 0
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,          5'b00000, 32'h0};
      vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,          5'b11000, IA};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h3C1D_0001,  5'b00010, 32'h0};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          5'b00000, 32'h0};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,          5'b00000, 32'h0};
      vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,          5'b10100, DA};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h1111_1111,  5'b00001, 32'h0};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,          5'b00000, 32'h0};
      vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,          5'b11000, IA};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h2222_2222,  5'b00010, 32'h0};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,          5'b00000, 32'h0};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,          5'b10000, DA};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          5'b00000, DA};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,          5'b00000, 32'h0};

      // reset state
      @(negedge clk);
      @(negedge clk);
      #1;
      check("reset_flags", 64'(flags()), 64'd0);
      check("reset_mem_addr", 64'(mem_addr), 64'd0);
      @(negedge clk);
      resetn = 1'b1;

      // table-driven transactions
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         inst_req    = vecs[i].ireq;
         data_req    = vecs[i].dreq;
         mem_addr_ok = vecs[i].maok;
         mem_data_ok = vecs[i].mdok;
         mem_rdata   = vecs[i].rdata;
         #1;
         check($sformatf("vec%0d_flags", i), 64'(flags()), 64'(vecs[i].exp_flags));
         check($sformatf("vec%0d_addr", i), 64'(mem_addr), 64'(vecs[i].exp_addr));
         check($sformatf("vec%0d_rdata", i), {inst_rdata, data_rdata}, {vecs[i].rdata, vecs[i].rdata});
      end

      // starvation guard: both masters request continuously
      @(negedge clk);
      inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'd0;
      seq = 10'd0;
      ngrant = 0;
      for (int c = 0; c < 40 && ngrant < 10; c++) begin
         #1;
         if (inst_addr_ok || data_addr_ok) begin
            seq = {seq[8:0], data_addr_ok};
            ngrant++;
         end
         if (ngrant < 10) @(negedge clk);
      end
      check("streak_grant_count", 64'(ngrant), 64'd10);
      check("streak_sequence", 64'(seq), 64'(10'b1111011110));
      @(negedge clk);
      inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
      @(negedge clk);
      mem_data_ok = 1'b0;

      // write pass-through with mem_addr_ok held low for 3 cycles
      @(negedge clk);
      data_req = 1'b1;
      #1;
      check("wr_idle_no_req", 64'(mem_req), 64'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         check($sformatf("wr_stall%0d_fields", c),
               {23'd0, mem_req, mem_wr, mem_size, mem_wstrb, data_addr_ok, mem_wdata},
               {23'd0, 1'b1, 1'b1, 2'd0, 4'h4, 1'b0, 32'h00AB_0000});
         check($sformatf("wr_stall%0d_addr", c), 64'(mem_addr), 64'(DA));
      end
      @(negedge clk);
      mem_addr_ok = 1'b1;
      #1;
      check("wr_accept", 64'(flags()), 64'(5'b10100));

      // response delayed 5 cycles while inst waits
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         data_req = 1'b0; mem_addr_ok = 1'b0; inst_req = 1'b1;
         #1;
         check($sformatf("resp_wait%0d", c), 64'(flags()), 64'd0);
      end
      @(negedge clk);
      inst_req = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_F00D;
      #1;
      check("resp_done_flags", 64'(flags()), 64'(5'b00001));
      check("resp_done_rdata", 64'(data_rdata), 64'(32'hCAFE_F00D));
      @(negedge clk);
      mem_data_ok = 1'b0;

      // asynchronous reset during RESP while data_ok is high
      @(negedge clk);
      inst_req = 1'b1;
      @(negedge clk);
      mem_addr_ok = 1'b1;
      #1;
      check("rst_pre_addr_ok", 64'(flags()), 64'(5'b11000));
      @(negedge clk);
      inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
      #1;
      check("rst_pre_data_ok", 64'(flags()), 64'(5'b00010));
      #1 resetn = 1'b0;
      #1;
      check("rst_resp_drop", 64'(flags()), 64'd0);
      @(negedge clk);
      resetn = 1'b1; mem_data_ok = 1'b0;

      // asynchronous reset during ADDR
      @(negedge clk);
      inst_req = 1'b1;
      @(negedge clk);
      mem_addr_ok = 1'b1;
      #1;
      check("rst_addr_pre", {27'd0, flags(), mem_addr}, {27'd0, 5'b11000, IA});
      #1 resetn = 1'b0;
      #1;
      check("rst_addr_drop", {27'd0, flags(), mem_addr}, 64'd0);
      @(negedge clk);
      inst_req = 1'b0; mem_addr_ok = 1'b0;
      @(negedge clk);
      resetn = 1'b1; mem_data_ok = 1'b1;

      // stray mem_data_ok after reset release is ignored
      for (int c = 0; c < 2; c++) begin
         #1;
         check($sformatf("stray_data_ok%0d", c), 64'(flags()), 64'd0);
         @(negedge clk);
      end
      mem_data_ok = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
